// File: rtl/cache2w_pkg.sv
// Shared definitions for the 2-way set-associative cache controller:
// address field positions, geometry, FSM state encoding and a block-address helper.
package cache2w_pkg;

   localparam int ADDR_W   = 10;
   localparam int TAG_W    = 5;
   localparam int SETS     = 2;
   localparam int WAYS     = 2;
   localparam int STAT_W   = 16;

   // Byte address layout: tag=[9:5], set=[4], word=[3:2], byte=[1:0]
   localparam int TAG_LSB  = 5;
   localparam int SET_BIT  = 4;
   localparam int WORD_LSB = 2;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOOKUP    = 3'd1,
      ST_WRITEBACK = 3'd2,
      ST_ALLOCATE  = 3'd3,
      ST_RESPOND   = 3'd4
   } state_t;

   // Block-aligned memory address built from a tag and a set index.
   function automatic logic [ADDR_W-1:0] block_addr(input logic [TAG_W-1:0] tag, input logic set);
      return {tag, set, 4'b0000};
   endfunction

endpackage

// File: rtl/cache2w_tag_store.sv
// Metadata store for the 2-way cache: valid/dirty/tag per way and one LRU bit per set.
// Lookup is purely combinational on the presented set/tag; updates take effect on the clock edge.
module cache2w_tag_store
   import cache2w_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_set,
   input  logic [TAG_W-1:0] i_tag,
   output logic             o_hit,
   output logic             o_hit_way,
   output logic             o_victim_way,
   output logic             o_victim_dirty,
   output logic [TAG_W-1:0] o_victim_tag,
   input  logic             i_upd_way,
   input  logic             i_clean_en,
   input  logic             i_fill_en,
   input  logic             i_touch_en,
   input  logic             i_touch_dirty
);

   logic [SETS-1:0][WAYS-1:0]            r_valid;
   logic [SETS-1:0][WAYS-1:0]            r_dirty;
   logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] r_tag;
   logic [SETS-1:0]                      r_lru;
   logic [WAYS-1:0]                      w_match;

   genvar gi;
   generate
      for (gi = 0; gi < WAYS; gi++) begin : g_match
         assign w_match[gi] = r_valid[i_set][gi] && (r_tag[i_set][gi] == i_tag);
      end
   endgenerate

   // Hit resolution (way0 preferred) and victim choice (first invalid way, else LRU).
   always_comb begin
      o_hit        = |w_match;
      o_hit_way    = ~w_match[0];
      if (!r_valid[i_set][0])
         o_victim_way = 1'b0;
      else if (!r_valid[i_set][1])
         o_victim_way = 1'b1;
      else
         o_victim_way = r_lru[i_set];
      o_victim_dirty = r_valid[i_set][o_victim_way] && r_dirty[i_set][o_victim_way];
      o_victim_tag   = r_tag[i_set][o_victim_way];
   end

   // Metadata updates: writeback clears dirty, refill installs a clean line, access updates LRU/dirty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_dirty <= '0;
         r_tag   <= '0;
         r_lru   <= '0;
      end else begin
         if (i_clean_en)
            r_dirty[i_set][i_upd_way] <= 1'b0;
         if (i_fill_en) begin
            r_tag[i_set][i_upd_way]   <= i_tag;
            r_valid[i_set][i_upd_way] <= 1'b1;
            r_dirty[i_set][i_upd_way] <= 1'b0;
         end
         if (i_touch_en) begin
            r_lru[i_set] <= ~i_upd_way;
            if (i_touch_dirty)
               r_dirty[i_set][i_upd_way] <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/cache2w_ctrl.sv
// Sequencing controller for the 2-way write-back cache: request capture, lookup,
// victim writeback, refill and response, plus saturating hit/miss statistics.
module cache2w_ctrl
   import cache2w_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cpu_req,
   input  logic              cpu_read_write,
   input  logic [ADDR_W-1:0] cpu_address,
   output logic              cpu_ready,
   output logic              hit,
   output logic              arr_set,
   output logic              arr_way,
   output logic [1:0]        arr_word,
   output logic              arr_wr_en,
   output logic              arr_fill_en,
   output logic              mem_req,
   output logic              mem_read_write,
   output logic [ADDR_W-1:0] mem_address,
   input  logic              mem_ready,
   output logic [STAT_W-1:0] stat_hits,
   output logic [STAT_W-1:0] stat_misses
);

   state_t                   r_state;
   state_t                   w_state_next;
   logic                     r_rw;
   logic [ADDR_W-1:WORD_LSB] r_addr;
   logic                     r_hit;
   logic                     r_way;
   logic [TAG_W-1:0]         r_vtag;
   logic [STAT_W-1:0]        r_stat_hits;
   logic [STAT_W-1:0]        r_stat_misses;

   logic                     w_set;
   logic [TAG_W-1:0]         w_tag;
   logic                     w_hit;
   logic                     w_hit_way;
   logic                     w_victim_way;
   logic                     w_victim_dirty;
   logic [TAG_W-1:0]         w_victim_tag;
   logic                     w_clean_en;
   logic                     w_fill_en;
   logic                     w_touch_en;
   logic                     w_unused;

   // Byte-lane bits are not needed: the data array handles the byte itself.
   assign w_unused    = ^cpu_address[WORD_LSB-1:0];
   assign w_set       = r_addr[SET_BIT];
   assign w_tag       = r_addr[ADDR_W-1:TAG_LSB];
   assign stat_hits   = r_stat_hits;
   assign stat_misses = r_stat_misses;

   cache2w_tag_store u_tags (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_set          (w_set),
      .i_tag          (w_tag),
      .o_hit          (w_hit),
      .o_hit_way      (w_hit_way),
      .o_victim_way   (w_victim_way),
      .o_victim_dirty (w_victim_dirty),
      .o_victim_tag   (w_victim_tag),
      .i_upd_way      (r_way),
      .i_clean_en     (w_clean_en),
      .i_fill_en      (w_fill_en),
      .i_touch_en     (w_touch_en),
      .i_touch_dirty  (r_rw)
   );

   // State register plus request/lookup capture and statistics.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_rw          <= 1'b0;
         r_addr        <= '0;
         r_hit         <= 1'b0;
         r_way         <= 1'b0;
         r_vtag        <= '0;
         r_stat_hits   <= '0;
         r_stat_misses <= '0;
      end else begin
         r_state <= w_state_next;
         if (r_state == ST_IDLE && cpu_req) begin
            r_rw   <= cpu_read_write;
            r_addr <= cpu_address[ADDR_W-1:WORD_LSB];
         end
         if (r_state == ST_LOOKUP) begin
            r_hit  <= w_hit;
            r_way  <= w_hit ? w_hit_way : w_victim_way;
            r_vtag <= w_victim_tag;
         end
         if (r_state == ST_RESPOND) begin
            if (r_hit && r_stat_hits != '1)
               r_stat_hits <= r_stat_hits + STAT_W'(1);
            if (!r_hit && r_stat_misses != '1)
               r_stat_misses <= r_stat_misses + STAT_W'(1);
         end
      end
   end

   // Next-state decode and all strobes; outputs are quiet unless a state drives them.
   always_comb begin
      w_state_next   = r_state;
      cpu_ready      = 1'b0;
      hit            = 1'b0;
      arr_set        = 1'b0;
      arr_way        = 1'b0;
      arr_word       = 2'b00;
      arr_wr_en      = 1'b0;
      arr_fill_en    = 1'b0;
      mem_req        = 1'b0;
      mem_read_write = 1'b0;
      mem_address    = '0;
      w_clean_en     = 1'b0;
      w_fill_en      = 1'b0;
      w_touch_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (cpu_req)
               w_state_next = ST_LOOKUP;
         end
         ST_LOOKUP: begin
            arr_set = w_set;
            if (w_hit)
               w_state_next = ST_RESPOND;
            else if (w_victim_dirty)
               w_state_next = ST_WRITEBACK;
            else
               w_state_next = ST_ALLOCATE;
         end
         ST_WRITEBACK: begin
            mem_req        = 1'b1;
            mem_read_write = 1'b1;
            mem_address    = block_addr(r_vtag, w_set);
            arr_set        = w_set;
            arr_way        = r_way;
            if (mem_ready) begin
               w_clean_en   = 1'b1;
               w_state_next = ST_ALLOCATE;
            end
         end
         ST_ALLOCATE: begin
            mem_req     = 1'b1;
            mem_address = block_addr(w_tag, w_set);
            arr_set     = w_set;
            arr_way     = r_way;
            if (mem_ready) begin
               arr_fill_en  = 1'b1;
               w_fill_en    = 1'b1;
               w_state_next = ST_RESPOND;
            end
         end
         ST_RESPOND: begin
            cpu_ready    = 1'b1;
            hit          = r_hit;
            arr_set      = w_set;
            arr_way      = r_way;
            arr_word     = r_addr[WORD_LSB+1:WORD_LSB];
            arr_wr_en    = r_rw;
            w_touch_en   = 1'b1;
            w_state_next = ST_IDLE;
         end
         default: w_state_next = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_cache2w_ctrl.sv
// Directed bench for cache2w_ctrl: hand-computed hit/miss, victim, writeback,
// abort-on-reset, long memory wait and counter saturation scenarios.
module tb_cache2w_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cpu_req = 1'b0;
   logic        cpu_read_write = 1'b0;
   logic [9:0]  cpu_address = '0;
   logic        cpu_ready;
   logic        hit;
   logic        arr_set;
   logic        arr_way;
   logic [1:0]  arr_word;
   logic        arr_wr_en;
   logic        arr_fill_en;
   logic        mem_req;
   logic        mem_read_write;
   logic [9:0]  mem_address;
   logic        mem_ready = 1'b0;
   logic [15:0] stat_hits;
   logic [15:0] stat_misses;

   int n_chk = 0;
   int n_err = 0;
   int last_lat = 0;

   always #5 clk = ~clk;

   cache2w_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .cpu_req        (cpu_req),
      .cpu_read_write (cpu_read_write),
      .cpu_address    (cpu_address),
      .cpu_ready      (cpu_ready),
      .hit            (hit),
      .arr_set        (arr_set),
      .arr_way        (arr_way),
      .arr_word       (arr_word),
      .arr_wr_en      (arr_wr_en),
      .arr_fill_en    (arr_fill_en),
      .mem_req        (mem_req),
      .mem_read_write (mem_read_write),
      .mem_address    (mem_address),
      .mem_ready      (mem_ready),
      .stat_hits      (stat_hits),
      .stat_misses    (stat_misses)
   );

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic apply_reset();
      cpu_req = 1'b0; cpu_read_write = 1'b0; cpu_address = '0; mem_ready = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      check_val("rst.outs", {cpu_ready, hit, arr_set, arr_way, arr_word, arr_wr_en, arr_fill_en,
                             mem_req, mem_read_write, mem_address}, 32'd0);
      check_val("rst.stats", {stat_hits, stat_misses}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One CPU access with a memory responder that answers after wait_n stall cycles.
   task automatic do_access(input string nm, input logic rw, input logic [9:0] addr,
                            input logic exp_hit, input logic exp_way, input logic exp_wb,
                            input logic [9:0] exp_wb_addr, input int wait_n, input logic toggle);
      int n = 0;
      int wcnt = 0;
      int unstable = 0;
      logic got = 1'b0, got_hit = 1'b0, got_way = 1'b0, got_wr = 1'b0, got_set = 1'b0;
      logic [1:0] got_word = 2'b00;
      logic seen_wb = 1'b0, seen_al = 1'b0, fill_seen = 1'b0, fill_way = 1'b0, in_phase = 1'b0;
      logic [9:0] wb_addr = '0, al_addr = '0;
      logic [15:0] snap = '0;
      @(negedge clk);
      cpu_req = 1'b1; cpu_read_write = rw; cpu_address = addr; mem_ready = 1'b0;
      while (!got && n < 300) begin
         @(posedge clk);
         #1;
         n++;
         mem_ready = 1'b0;
         if (cpu_ready) begin
            got = 1'b1; got_hit = hit; got_way = arr_way; got_set = arr_set;
            got_word = arr_word; got_wr = arr_wr_en;
            cpu_req = 1'b0;
         end else if (mem_req) begin
            if (!in_phase) begin
               in_phase = 1'b1;
               wcnt = 0;
               snap = {mem_read_write, mem_address, arr_set, arr_way, arr_word};
               if (mem_read_write) begin seen_wb = 1'b1; wb_addr = mem_address; end
               else begin seen_al = 1'b1; al_addr = mem_address; end
            end else if ({mem_read_write, mem_address, arr_set, arr_way, arr_word} != snap) begin
               unstable++;
            end
            if (wcnt == wait_n) begin
               mem_ready = 1'b1;
               in_phase = 1'b0;
               #1;
               if (!mem_read_write) begin fill_seen = arr_fill_en; fill_way = arr_way; end
            end else begin
               wcnt++;
               if (toggle) begin
                  cpu_address = 10'($urandom);
                  cpu_req = ~cpu_req;
               end
            end
         end
      end
      mem_ready = 1'b0;
      last_lat = n;
      check_val({nm, ".done"}, 32'(got), 32'd1);
      check_val({nm, ".hit"}, 32'(got_hit), 32'(exp_hit));
      check_val({nm, ".way"}, 32'(got_way), 32'(exp_way));
      check_val({nm, ".setword"}, {got_set, got_word}, {addr[4], addr[3:2]});
      check_val({nm, ".wr_en"}, 32'(got_wr), 32'(rw));
      check_val({nm, ".wb"}, 32'(seen_wb), 32'(exp_wb));
      if (exp_wb)
         check_val({nm, ".wb_addr"}, 32'(wb_addr), 32'(exp_wb_addr));
      check_val({nm, ".alloc"}, 32'(seen_al), 32'(!exp_hit));
      if (!exp_hit) begin
         check_val({nm, ".al_addr"}, 32'(al_addr), {addr[9:4], 4'b0000});
         check_val({nm, ".fill"}, 32'(fill_seen), 32'd1);
         check_val({nm, ".fill_way"}, 32'(fill_way), 32'(exp_way));
         check_val({nm, ".stable"}, 32'(unstable), 32'd0);
      end else begin
         check_val({nm, ".lat"}, 32'(n), 32'd2);
      end
      @(posedge clk);
      #1;
      check_val({nm, ".idle"}, 32'(cpu_ready), 32'd0);
      $display("txn %s rw=%0d addr=%03h hit=%0d way=%0d wb=%0d lat=%0d",
               nm, rw, addr, got_hit, got_way, seen_wb, n);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int ready_cnt;

      // 1: clean miss into set1 way0, then hits (read and write)
      apply_reset();
      do_access("t1.miss", 1'b0, 10'h010, 1'b0, 1'b0, 1'b0, 10'h000, 3, 1'b0);
      check_val("t1.miss_lat", 32'(last_lat), 32'd6);
      do_access("t1.hit", 1'b0, 10'h010, 1'b1, 1'b0, 1'b0, 10'h000, 3, 1'b0);
      do_access("t1.whit", 1'b1, 10'h014, 1'b1, 1'b0, 1'b0, 10'h000, 3, 1'b0);
      do_access("t1.miss1", 1'b0, 10'h030, 1'b0, 1'b1, 1'b0, 10'h000, 1, 1'b0);
      check_val("t1.stats", {stat_hits, stat_misses}, {16'd2, 16'd2});

      // 2: LRU victim selection, clean eviction
      apply_reset();
      do_access("t2.r000", 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      do_access("t2.r020", 1'b0, 10'h020, 1'b0, 1'b1, 1'b0, 10'h000, 2, 1'b0);
      do_access("t2.r000h", 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      do_access("t2.r040", 1'b0, 10'h040, 1'b0, 1'b1, 1'b0, 10'h000, 1, 1'b0);
      check_val("t2.stats", {stat_hits, stat_misses}, {16'd1, 16'd3});

      // 3: dirty victims force a writeback before refill
      apply_reset();
      do_access("t3.w000", 1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1, 1'b0);
      do_access("t3.w020", 1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 10'h000, 1, 1'b0);
      do_access("t3.r040", 1'b0, 10'h040, 1'b0, 1'b0, 1'b1, 10'h000, 2, 1'b0);
      do_access("t3.r020h", 1'b0, 10'h020, 1'b1, 1'b1, 1'b0, 10'h000, 0, 1'b0);
      do_access("t3.r000", 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1, 1'b0);
      do_access("t3.r060", 1'b0, 10'h060, 1'b0, 1'b1, 1'b1, 10'h020, 1, 1'b0);
      check_val("t3.stats", {stat_hits, stat_misses}, {16'd1, 16'd5});

      // 4: asynchronous reset while a writeback is outstanding
      apply_reset();
      do_access("t4.w000", 1'b1, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      do_access("t4.w020", 1'b1, 10'h020, 1'b0, 1'b1, 1'b0, 10'h000, 0, 1'b0);
      @(negedge clk);
      cpu_req = 1'b1; cpu_read_write = 1'b0; cpu_address = 10'h040; mem_ready = 1'b0;
      k = 0;
      while (!mem_req && k < 20) begin
         @(posedge clk);
         #1;
         k++;
      end
      check_val("t4.in_wb", {mem_req, mem_read_write, mem_address}, {2'b11, 10'h000});
      #2 rst_n = 1'b0;
      #1;
      check_val("t4.abort", {mem_req, cpu_ready}, 32'd0);
      check_val("t4.stats_clr", {stat_hits, stat_misses}, 32'd0);
      cpu_req = 1'b0;
      ready_cnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         ready_cnt += int'(cpu_ready);
      end
      check_val("t4.no_ready", 32'(ready_cnt), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      do_access("t4.r000", 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 1, 1'b0);
      check_val("t4.stats", {stat_hits, stat_misses}, {16'd0, 16'd1});

      // 5: long memory stall with the CPU inputs wiggling
      apply_reset();
      do_access("t5.stall", 1'b0, 10'h010, 1'b0, 1'b0, 1'b0, 10'h000, 20, 1'b1);
      ready_cnt = 0;
      repeat (3) begin
         @(posedge clk);
         #1;
         ready_cnt += int'(cpu_ready);
      end
      check_val("t5.single_ready", 32'(ready_cnt), 32'd0);
      check_val("t5.stats", {stat_hits, stat_misses}, {16'd0, 16'd1});

      // 6: hit counter saturates at all-ones
      apply_reset();
      do_access("t6.fill", 1'b0, 10'h000, 1'b0, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      @(negedge clk);
      force dut.r_stat_hits = 16'hFFFE;
      #1;
      release dut.r_stat_hits;
      #1;
      check_val("t6.preset", 32'(stat_hits), 32'hFFFE);
      do_access("t6.h1", 1'b0, 10'h000, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      check_val("t6.h1_cnt", 32'(stat_hits), 32'hFFFF);
      do_access("t6.h2", 1'b0, 10'h004, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      do_access("t6.h3", 1'b0, 10'h008, 1'b1, 1'b0, 1'b0, 10'h000, 0, 1'b0);
      check_val("t6.sat", 32'(stat_hits), 32'hFFFF);
      check_val("t6.misses", 32'(stat_misses), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
